// File: rtl/rx_frame_asm.sv
// Purpose : assembles UART RX bytes into WREQ/RREQ/RRES frames (7/3/5 bytes incl. command byte).
// Latency : Frame_VLD one cycle after the last byte's RxVLD when FFULL=0; Err one cycle after the cause.
// Backpr. : FFULL holds the completed frame in DONE; bytes arriving meanwhile are dropped as overrun.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RxData/RxVLD    received byte and its one-cycle strobe; ParErr flags a bad byte
//   FFULL           downstream frame FIFO full
//   PData/CMD       assembled frame (first byte at [55:48]) and its command
//   Frame_VLD       one-cycle frame write strobe
//   RBUSY           frame in progress or pending
//   Err/ErrCode     one-cycle error strobe; 0 bad CMD, 1 parity, 2 timeout, 3 overrun
module rx_frame_asm #(
    parameter int TO_CYC = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RxData,
    input  logic        RxVLD,
    input  logic        ParErr,
    input  logic        FFULL,
    output logic [55:0] PData,
    output logic [2:0]  CMD,
    output logic        Frame_VLD,
    output logic        RBUSY,
    output logic        Err,
    output logic [1:0]  ErrCode
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [2:0]  CMD_WREQ = 3'd2;
    localparam logic [2:0]  CMD_RREQ = 3'd3;
    localparam logic [2:0]  CMD_RRES = 3'd4;
    localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);

    localparam logic [1:0] EC_BADCMD  = 2'd0;
    localparam logic [1:0] EC_PARITY  = 2'd1;
    localparam logic [1:0] EC_TIMEOUT = 2'd2;
    localparam logic [1:0] EC_OVERRUN = 2'd3;

    state_t      state_q, state_d;
    logic [55:0] pdata_q, pdata_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fvld_q, fvld_d;
    logic        rbusy_q, rbusy_d;
    logic        err_q, err_d;
    logic [1:0]  ecode_q, ecode_d;

    function automatic logic cmd_ok(input logic [7:0] b);
        return (b[7:3] == 5'd0) &&
               ((b[2:0] == CMD_WREQ) || (b[2:0] == CMD_RREQ) || (b[2:0] == CMD_RRES));
    endfunction

    // Index of the final byte of a frame (frame length minus one).
    function automatic logic [2:0] last_idx(input logic [2:0] c);
        case (c)
            CMD_WREQ: return 3'd6;
            CMD_RREQ: return 3'd2;
            CMD_RRES: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        pdata_d = pdata_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fvld_d  = 1'b0;
        err_d   = 1'b0;
        ecode_d = ecode_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (RxVLD) begin
                    if (ParErr) begin
                        err_d   = 1'b1;
                        ecode_d = EC_PARITY;
                    end else if (cmd_ok(RxData)) begin
                        pdata_d = {RxData, 48'h0};
                        cmd_d   = RxData[2:0];
                        idx_d   = 3'd1;
                        state_d = COLLECT;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = EC_BADCMD;
                    end
                end
            end

            COLLECT: begin
                if (RxVLD) begin
                    if (ParErr) begin
                        err_d   = 1'b1;
                        ecode_d = EC_PARITY;
                        pdata_d = '0;
                        cmd_d   = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        for (int i = 1; i < 7; i++) begin
                            if (idx_q == 3'(i)) begin
                                pdata_d[8*(6-i) +: 8] = RxData;
                            end
                        end
                        cnt_d = '0;
                        if (idx_q == last_idx(cmd_q)) begin
                            // Emit straight away when the FIFO has room so the strobe
                            // lands one cycle after the final byte.
                            state_d = DONE;
                            fvld_d  = !FFULL;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    ecode_d = EC_TIMEOUT;
                    pdata_d = '0;
                    cmd_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DONE: begin
                // fvld_q marks that the strobe is being presented this cycle, so the
                // frame has been delivered and the block leaves DONE.
                if (fvld_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    if (RxVLD) begin
                        err_d   = 1'b1;
                        ecode_d = EC_OVERRUN;
                    end
                end else if (RxVLD) begin
                    // Overrun wins over emission this cycle so Err and Frame_VLD never
                    // coincide; FFULL is looked at again on the next cycle.
                    err_d   = 1'b1;
                    ecode_d = EC_OVERRUN;
                end else if (!FFULL) begin
                    fvld_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rbusy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pdata_q <= '0;
            cmd_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fvld_q  <= 1'b0;
            rbusy_q <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            pdata_q <= pdata_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fvld_q  <= fvld_d;
            rbusy_q <= rbusy_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    assign PData     = pdata_q;
    assign CMD       = cmd_q;
    assign Frame_VLD = fvld_q;
    assign RBUSY     = rbusy_q;
    assign Err       = err_q;
    assign ErrCode   = ecode_q;

endmodule

// File: tb/tb_rx_frame_asm.sv
// Purpose : scoreboard bench for rx_frame_asm; directed frames then randomized traffic.
// Latency : checks Frame_VLD one cycle after the last byte and after FFULL release.
// Backpr. : exercises FFULL holds with overrun bytes injected during the hold.
module tb_rx_frame_asm;

    localparam int TO_CYC = 16;

    logic        CLK;
    logic        RST;
    logic [7:0]  RxData;
    logic        RxVLD;
    logic        ParErr;
    logic        FFULL;
    logic [55:0] PData;
    logic [2:0]  CMD;
    logic        Frame_VLD;
    logic        RBUSY;
    logic        Err;
    logic [1:0]  ErrCode;

    rx_frame_asm #(.TO_CYC(TO_CYC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RxData    (RxData),
        .RxVLD     (RxVLD),
        .ParErr    (ParErr),
        .FFULL     (FFULL),
        .PData     (PData),
        .CMD       (CMD),
        .Frame_VLD (Frame_VLD),
        .RBUSY     (RBUSY),
        .Err       (Err),
        .ErrCode   (ErrCode)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        is_frame;
        logic [55:0] pdata;
        logic [2:0]  cmd;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int frame_len(input logic [2:0] c);
        case (c)
            3'd2:    return 7;
            3'd3:    return 3;
            3'd4:    return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic cmd_valid(input logic [7:0] x);
        return (x[7:3] == 5'd0) && (x[2:0] >= 3'd2) && (x[2:0] <= 3'd4);
    endfunction

    function automatic logic [55:0] model_pdata(input logic [7:0] b[7], input int n);
        logic [55:0] p;
        p = '0;
        for (int i = 0; i < n; i++) p = p | (56'(b[i]) << (8 * (6 - i)));
        return p;
    endfunction

    function automatic void push_frame(input logic [55:0] p, input logic [2:0] c);
        exp_t e;
        e.is_frame = 1'b1;
        e.pdata    = p;
        e.cmd      = c;
        e.code     = 2'd0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_err(input logic [1:0] code);
        exp_t e;
        e.is_frame = 1'b0;
        e.pdata    = '0;
        e.cmd      = '0;
        e.code     = code;
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (!RST && (Frame_VLD || Err)) begin
            chk("strobe_exclusive", {63'b0, Frame_VLD & Err}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: Frame_VLD=%0b Err=%0b ErrCode=%0d PData=%h, none expected",
                         Frame_VLD, Err, ErrCode, PData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", {63'b0, Frame_VLD}, {63'b0, mon_e.is_frame});
                if (mon_e.is_frame) begin
                    chk("frame_pdata", {8'b0, PData}, {8'b0, mon_e.pdata});
                    chk("frame_cmd", {61'b0, CMD}, {61'b0, mon_e.cmd});
                end else begin
                    chk("err_code", {62'b0, ErrCode}, {62'b0, mon_e.code});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic pe);
        RxData = d;
        RxVLD  = 1'b1;
        ParErr = pe;
        tick();
        RxVLD  = 1'b0;
        ParErr = 1'b0;
        RxData = 8'($urandom);
    endtask

    function automatic int rand_gap();
        return ($urandom_range(0, 7) == 0) ? TO_CYC - 1 : $urandom_range(0, 3);
    endfunction

    // Sends n bytes back to back and checks the strobe one cycle after the last.
    task automatic run_frame(input logic [7:0] b[7], input int n, input string name);
        for (int i = 0; i < n; i++) send(b[i], 1'b0);
        @(negedge CLK);
        chk(name, {63'b0, Frame_VLD}, 64'd1);
        gap(2);
    endtask

    task automatic rand_frame();
        int          kind;
        int          len;
        int          k;
        int          hold;
        logic [7:0]  b[7];
        logic [7:0]  x;
        logic [2:0]  c;
        kind = $urandom_range(0, 9);
        c    = 3'($urandom_range(2, 4));
        len  = frame_len(c);
        b[0] = {5'b0, c};
        for (int i = 1; i < 7; i++) b[i] = 8'($urandom);
        case (kind)
            0: begin
                x = 8'($urandom);
                if (cmd_valid(x)) x[7] = 1'b1;
                push_err(2'd0);
                send(x, 1'b0);
                gap($urandom_range(0, 2));
            end
            1: begin
                push_err(2'd1);
                send(8'($urandom), 1'b1);
                gap($urandom_range(0, 2));
            end
            2: begin
                k = $urandom_range(1, len - 1);
                for (int i = 0; i < k; i++) begin
                    if (i > 0) gap(rand_gap());
                    send(b[i], 1'b0);
                end
                gap(rand_gap());
                push_err(2'd1);
                send(b[k], 1'b1);
                gap($urandom_range(0, 2));
            end
            3: begin
                k = $urandom_range(1, len - 1);
                for (int i = 0; i < k; i++) begin
                    if (i > 0) gap(rand_gap());
                    send(b[i], 1'b0);
                end
                push_err(2'd2);
                gap(TO_CYC + 1);
            end
            default: begin
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
                if (hold == 0) push_frame(model_pdata(b, len), c);
                for (int i = 0; i < len; i++) begin
                    if (i > 0) gap(rand_gap());
                    if (i == len - 1 && hold > 0) FFULL = 1'b1;
                    send(b[i], 1'b0);
                end
                if (hold > 0) begin
                    for (int h = 0; h < hold; h++) begin
                        if ($urandom_range(0, 2) == 0) begin
                            push_err(2'd3);
                            send(8'($urandom), 1'b0);
                        end else begin
                            tick();
                        end
                    end
                    push_frame(model_pdata(b, len), c);
                    FFULL = 1'b0;
                    gap(2);
                end else begin
                    gap(1 + $urandom_range(0, 2));
                end
            end
        endcase
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    logic [7:0] fb[7];

    initial begin
        RST    = 1'b1;
        RxData = 8'h02;
        RxVLD  = 1'b1;
        ParErr = 1'b0;
        FFULL  = 1'b0;
        gap(3);
        @(negedge CLK);
        chk("rst_pdata", {8'b0, PData}, 64'd0);
        chk("rst_cmd", {61'b0, CMD}, 64'd0);
        chk("rst_fvld", {63'b0, Frame_VLD}, 64'd0);
        chk("rst_rbusy", {63'b0, RBUSY}, 64'd0);
        chk("rst_err", {63'b0, Err}, 64'd0);
        chk("rst_ecode", {62'b0, ErrCode}, 64'd0);
        RxVLD = 1'b0;
        RST   = 1'b0;
        gap(2);

        // WREQ
        fb = '{8'h02, 8'h12, 8'h34, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        push_frame(56'h02_1234_A1B2C3D4, 3'd2);
        send(fb[0], 1'b0);
        @(negedge CLK);
        chk("rbusy_collect", {63'b0, RBUSY}, 64'd1);
        for (int i = 1; i < 6; i++) send(fb[i], 1'b0);
        @(negedge CLK);
        chk("fvld_early", {63'b0, Frame_VLD}, 64'd0);
        send(fb[6], 1'b0);
        @(negedge CLK);
        chk("wreq_latency", {63'b0, Frame_VLD}, 64'd1);
        gap(1);
        @(negedge CLK);
        chk("wreq_pdata_after", {8'b0, PData}, 64'h0002_1234_A1B2_C3D4);
        chk("wreq_rbusy_after", {63'b0, RBUSY}, 64'd0);
        gap(1);

        // RREQ and RRES with zero tail bytes
        fb = '{8'h03, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(56'h03_ABCD_00000000, 3'd3);
        run_frame(fb, 3, "rreq_latency");
        fb = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        push_frame(56'h04_11223344_0000, 3'd4);
        run_frame(fb, 5, "rres_latency");

        // Bad command then a good frame
        push_err(2'd0);
        send(8'h07, 1'b0);
        @(negedge CLK);
        chk("badcmd_err", {63'b0, Err}, 64'd1);
        chk("badcmd_rbusy", {63'b0, RBUSY}, 64'd0);
        fb = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(56'h03_0010_00000000, 3'd3);
        run_frame(fb, 3, "after_badcmd_latency");

        // Timeout after three WREQ bytes
        push_err(2'd2);
        send(8'h02, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        gap(TO_CYC - 1);
        @(negedge CLK);
        chk("to_not_yet", {63'b0, Err}, 64'd0);
        chk("to_rbusy_before", {63'b0, RBUSY}, 64'd1);
        gap(1);
        @(negedge CLK);
        chk("to_err", {63'b0, Err}, 64'd1);
        chk("to_code", {62'b0, ErrCode}, 64'd2);
        chk("to_rbusy", {63'b0, RBUSY}, 64'd0);
        chk("to_fvld", {63'b0, Frame_VLD}, 64'd0);
        gap(2);

        // Bytes landing exactly on the last counter value are accepted
        push_frame(56'h03_5566_00000000, 3'd3);
        send(8'h03, 1'b0);
        gap(TO_CYC - 1);
        send(8'h55, 1'b0);
        gap(TO_CYC - 1);
        send(8'h66, 1'b0);
        @(negedge CLK);
        chk("to_boundary_fvld", {63'b0, Frame_VLD}, 64'd1);
        gap(2);

        // RRES held by FFULL with an overrun byte
        push_err(2'd3);
        push_frame(56'h04_11223344_0000, 3'd4);
        FFULL = 1'b1;
        fb = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) send(fb[i], 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send(8'h55, 1'b0);
            else tick();
            @(negedge CLK);
            chk("hold_fvld", {63'b0, Frame_VLD}, 64'd0);
            chk("hold_pdata", {8'b0, PData}, 64'h0004_1122_3344_0000);
            chk("hold_rbusy", {63'b0, RBUSY}, 64'd1);
        end
        FFULL = 1'b0;
        tick();
        @(negedge CLK);
        chk("release_fvld", {63'b0, Frame_VLD}, 64'd1);
        gap(2);

        // Parity error on byte index 4 of a WREQ
        push_err(2'd1);
        fb = '{8'h02, 8'h12, 8'h34, 8'hA1, 8'hB2, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) send(fb[i], 1'b0);
        send(fb[4], 1'b1);
        @(negedge CLK);
        chk("par_err", {63'b0, Err}, 64'd1);
        chk("par_code", {62'b0, ErrCode}, 64'd1);
        chk("par_pdata", {8'b0, PData}, 64'd0);
        chk("par_rbusy", {63'b0, RBUSY}, 64'd0);
        gap(2);

        // Reset mid-RRES, colliding with a byte
        send(8'h04, 1'b0);
        send(8'h11, 1'b0);
        RST    = 1'b1;
        RxVLD  = 1'b1;
        RxData = 8'h22;
        tick();
        RST   = 1'b0;
        RxVLD = 1'b0;
        @(negedge CLK);
        chk("midrst_pdata", {8'b0, PData}, 64'd0);
        chk("midrst_cmd", {61'b0, CMD}, 64'd0);
        chk("midrst_rbusy", {63'b0, RBUSY}, 64'd0);
        chk("midrst_err", {63'b0, Err}, 64'd0);
        chk("midrst_ecode", {62'b0, ErrCode}, 64'd0);
        chk("midrst_fvld", {63'b0, Frame_VLD}, 64'd0);
        gap(TO_CYC + 4);

        // Randomized traffic
        for (int n = 0; n < 200; n++) rand_frame();

        gap(TO_CYC + 4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
